// File: rtl/branch_target_predictor.sv
// Tagged direct-mapped branch target buffer with per-entry saturating
// direction counters and a saturating misprediction statistics counter.
module branch_target_predictor #(
  parameter int ADDR_WIDTH = 16,
  parameter int ENTRIES    = 16,
  parameter int CTR_BITS   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  predict_valid,
  output logic                  predict_hit,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_mispredict,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK =
    CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  valid_q [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q   [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic                lk_taken;

  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;

  assign lk_idx   = lookup_pc[IDX_BITS-1:0];
  assign lk_tag   = lookup_pc[ADDR_WIDTH-1:IDX_BITS];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];

  assign up_idx = update_pc[IDX_BITS-1:0];
  assign up_tag = update_pc[ADDR_WIDTH-1:IDX_BITS];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup reads the pre-update table: no bypass from the update port.
  always_ff @(posedge clk) begin
    if (reset) begin
      predict_valid  <= 1'b0;
      predict_hit    <= 1'b0;
      predict_taken  <= 1'b0;
      predict_target <= '0;
    end else begin
      predict_valid <= lookup_valid;
      predict_hit   <= lookup_valid && lk_hit;
      predict_taken <= lookup_valid && lk_taken;
      if (lookup_valid) begin
        predict_target <= lk_taken ? tgt_q[lk_idx]
                                   : lookup_pc + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
    end else if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          if (ctr_q[up_idx] != CTR_MAX)
            ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (update_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WEAK;
      end
    end
  end

  // Tag and target need no reset; a taken update either refreshes a hit
  // (same tag) or allocates over whatever occupied the slot.
  always_ff @(posedge clk) begin
    if (!reset && update_valid && update_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= update_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (update_valid && update_mispredict &&
                 mispredict_count != CNT_MAX) begin
      mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed vector table, reference
// model over random traffic, and misprediction counter saturation.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [15:0] lookup_pc;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_mispredict;

  logic        pv  [2];
  logic        ph  [2];
  logic        pt  [2];
  logic [15:0] ptg [2];
  logic [15:0] mc  [2];

  always #5 clk = ~clk;

  branch_target_predictor #(
    .ADDR_WIDTH(16), .ENTRIES(16), .CTR_BITS(2), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(pv[0]), .predict_hit(ph[0]),
    .predict_taken(pt[0]), .predict_target(ptg[0]),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .mispredict_count(mc[0])
  );

  branch_target_predictor #(
    .ADDR_WIDTH(16), .ENTRIES(4), .CTR_BITS(3), .CNT_WIDTH(16)
  ) dut4 (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(pv[1]), .predict_hit(ph[1]),
    .predict_taken(pt[1]), .predict_target(ptg[1]),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .mispredict_count(mc[1])
  );

  int checks = 0;
  int failures = 0;

  // Reference model: plain arrays and integer arithmetic per config.
  int ment [2] = '{16, 4};
  int mcb  [2] = '{2, 3};
  bit mv   [2][16];
  int mtag [2][16];
  int mtgt [2][16];
  int mctr [2][16];
  int mcnt;
  bit ev [2];
  bit eh [2];
  bit et [2];
  int etg [2];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit lv, int lpc, bit uv, int upc,
                       bit ut, int utgt, bit um);
    @(negedge clk);
    reset             = r;
    lookup_valid      = lv;
    lookup_pc         = 16'(lpc);
    update_valid      = uv;
    update_pc         = 16'(upc);
    update_taken      = ut;
    update_target     = 16'(utgt);
    update_mispredict = um;
  endtask

  task automatic model_cycle();
    int idx, tg, half, top;
    for (int k = 0; k < 2; k++) begin
      half = 1 << (mcb[k] - 1);
      top  = (1 << mcb[k]) - 1;
      if (reset) begin
        ev[k] = 0; eh[k] = 0; et[k] = 0; etg[k] = 0;
        for (int i = 0; i < 16; i++) begin
          mv[k][i] = 0;
          mctr[k][i] = 0;
        end
        continue;
      end
      if (lookup_valid) begin
        idx = int'(lookup_pc) % ment[k];
        tg  = int'(lookup_pc) / ment[k];
        ev[k] = 1;
        eh[k] = mv[k][idx] && mtag[k][idx] == tg;
        et[k] = eh[k] && mctr[k][idx] >= half;
        etg[k] = et[k] ? mtgt[k][idx] : (int'(lookup_pc) + 1) % 65536;
      end else begin
        ev[k] = 0; eh[k] = 0; et[k] = 0;
      end
      if (update_valid) begin
        idx = int'(update_pc) % ment[k];
        tg  = int'(update_pc) / ment[k];
        if (mv[k][idx] && mtag[k][idx] == tg) begin
          if (update_taken) begin
            if (mctr[k][idx] < top) mctr[k][idx]++;
            mtgt[k][idx] = int'(update_target);
          end else if (mctr[k][idx] > 0) begin
            mctr[k][idx]--;
          end
        end else if (update_taken) begin
          mv[k][idx]   = 1;
          mtag[k][idx] = tg;
          mtgt[k][idx] = int'(update_target);
          mctr[k][idx] = half;
        end
      end
    end
    if (reset) mcnt = 0;
    else if (update_valid && update_mispredict && mcnt < 65535) mcnt++;
  endtask

  // Advance one clock with the model and compare both instances.
  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d_valid", k), int'(pv[k]), int'(ev[k]));
      chk($sformatf("m%0d_hit", k), int'(ph[k]), int'(eh[k]));
      chk($sformatf("m%0d_taken", k), int'(pt[k]), int'(et[k]));
      chk($sformatf("m%0d_target", k), int'(ptg[k]), etg[k]);
      chk($sformatf("m%0d_count", k), int'(mc[k]), mcnt);
    end
  endtask

  typedef struct {
    bit r; bit lv; int lpc; bit uv; int upc; bit ut; int utgt; bit um;
    int sel; bit ev; bit eh; bit et; int etg; int ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit lv, int lpc, bit uv, int upc,
                              bit ut, int utgt, bit um, int sel,
                              bit xv, bit xh, bit xt, int xtg, int xc);
    vec_t v;
    v.r = r; v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc;
    v.ut = ut; v.utgt = utgt; v.um = um; v.sel = sel;
    v.ev = xv; v.eh = xh; v.et = xt; v.etg = xtg; v.ecnt = xc;
    return v;
  endfunction

  initial begin
    // 16-entry, 2-bit counters
    tbl.push_back(mk(1,1,'h10, 0,0,0,0,0, 0, 0,0,0,'h0000, 0));
    tbl.push_back(mk(0,1,'h10, 0,0,0,0,0, 0, 1,0,0,'h0011, 0));
    tbl.push_back(mk(0,0,0, 1,'h10,1,'h40,0, 0, 0,0,0,'h0011, 0));
    tbl.push_back(mk(0,1,'h10, 0,0,0,0,0, 0, 1,1,1,'h0040, 0));
    tbl.push_back(mk(0,0,0, 1,'h10,0,0,0, 0, 0,0,0,'h0040, 0));
    tbl.push_back(mk(0,1,'h10, 1,'h10,0,0,0, 0, 1,1,0,'h0011, 0));
    tbl.push_back(mk(0,1,'h10, 0,0,0,0,0, 0, 1,1,0,'h0011, 0));
    tbl.push_back(mk(0,0,0, 1,'h10,0,0,0, 0, 0,0,0,'h0011, 0));
    tbl.push_back(mk(0,0,0, 1,'h10,0,0,0, 0, 0,0,0,'h0011, 0));
    tbl.push_back(mk(0,1,'h10, 1,'h10,1,'h50,0, 0, 1,1,0,'h0011, 0));
    tbl.push_back(mk(0,1,'h10, 0,0,0,0,0, 0, 1,1,0,'h0011, 0));
    tbl.push_back(mk(0,0,0, 1,'h10,1,'h40,0, 0, 0,0,0,'h0011, 0));
    tbl.push_back(mk(0,0,0, 1,'h20,1,'h80,0, 0, 0,0,0,'h0011, 0));
    tbl.push_back(mk(0,1,'h10, 0,0,0,0,0, 0, 1,0,0,'h0011, 0));
    tbl.push_back(mk(0,1,'h20, 0,0,0,0,0, 0, 1,1,1,'h0080, 0));
    tbl.push_back(mk(0,1,'h30, 1,'h30,1,'h99,0, 0, 1,0,0,'h0031, 0));
    tbl.push_back(mk(0,1,'h30, 0,0,0,0,0, 0, 1,1,1,'h0099, 0));
    tbl.push_back(mk(0,1,'hFFFF, 0,0,0,0,0, 0, 1,0,0,'h0000, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,1, 0, 0,0,0,'h0000, 0));
    tbl.push_back(mk(0,0,0, 1,'h05,0,0,1, 0, 0,0,0,'h0000, 1));
    tbl.push_back(mk(1,0,0, 0,0,0,0,0, 0, 0,0,0,'h0000, 0));
    tbl.push_back(mk(0,1,'h30, 0,0,0,0,0, 0, 1,0,0,'h0031, 0));
    // 4-entry, 3-bit counters
    tbl.push_back(mk(1,0,0, 0,0,0,0,0, 1, 0,0,0,'h0000, 0));
    tbl.push_back(mk(0,0,0, 1,'h10,1,'h100,0, 1, 0,0,0,'h0000, 0));
    tbl.push_back(mk(0,1,'h10, 1,'h10,0,0,0, 1, 1,1,1,'h0100, 0));
    tbl.push_back(mk(0,1,'h10, 0,0,0,0,0, 1, 1,1,0,'h0011, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0, 1,'h10,1,'h100,0, 1, 0,0,0,'h0011, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0, 1,'h10,0,0,0, 1, 0,0,0,'h0011, 0));
    tbl.push_back(mk(0,1,'h10, 1,'h10,0,0,0, 1, 1,1,1,'h0100, 0));
    tbl.push_back(mk(0,1,'h10, 0,0,0,0,0, 1, 1,1,0,'h0011, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].lv, tbl[i].lpc, tbl[i].uv, tbl[i].upc,
            tbl[i].ut, tbl[i].utgt, tbl[i].um);
      step();
      chk($sformatf("v%0d_valid", i), int'(pv[tbl[i].sel]), int'(tbl[i].ev));
      chk($sformatf("v%0d_hit", i), int'(ph[tbl[i].sel]), int'(tbl[i].eh));
      chk($sformatf("v%0d_taken", i), int'(pt[tbl[i].sel]), int'(tbl[i].et));
      chk($sformatf("v%0d_target", i), int'(ptg[tbl[i].sel]), tbl[i].etg);
      chk($sformatf("v%0d_count", i), int'(mc[tbl[i].sel]), tbl[i].ecnt);
    end

    // Random traffic over a small PC pool so hits and aliases are common.
    for (int n = 0; n < 3000; n++) begin
      int lpc, upc;
      lpc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16'hFFF0, 16'hFFFF))
                                        : int'($urandom_range(0, 63));
      upc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16'hFFF0, 16'hFFFF))
                                        : int'($urandom_range(0, 63));
      drive($urandom_range(0, 99) == 0, 1'($urandom), lpc,
            1'($urandom), upc, 1'($urandom),
            int'($urandom_range(0, 16'hFFFF)), 1'($urandom));
      step();
    end

    // Misprediction counter saturation.
    drive(1,0,0, 0,0,0,0,0);
    step();
    for (int n = 0; n < 65535 + 3; n++) begin
      drive(0,0,0, 1,'h7,0,0,1);
      step();
    end
    chk("count_saturated", int'(mc[0]), 'hFFFF);
    drive(0,0,0, 0,0,0,0,0);
    step();
    chk("count_hold", int'(mc[1]), 'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
